mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-ported unified memory between the core's instruction port (iram_*) and data port (dram_*).
- Sits between the core top and the memory/bus model.
- Arbitrates requests, holds the grant stable while a request is stalled, and tracks outstanding reads in order so that each read response is returned to the port that issued it.

Parameters:
- MAX_OUTSTANDING, 2: maximum reads in flight to memory; depth of the owner FIFO. Must be ≥1.
- Data width is `XLEN from config.svh; it is not a parameter.

Ports:
- clk  in  1  clock
- rst_b  in  1  asynchronous active-low reset
- iram_req/iram_write  in  1  instruction port request/write
- iram_wstrb  in  `XLEN/8  byte strobes
- iram_addr/iram_wdata  in  `XLEN  address/write data
- iram_ready  out  1  iram request accepted this cycle
- iram_rvalid  out  1  read data valid for iram
- iram_rdata  out  `XLEN  read data
- dram_req/dram_write/dram_wstrb/dram_addr/dram_wdata, dram_ready/dram_rvalid/dram_rdata: same as iram_*, for the data port
- mem_req/mem_write  out  1  shared memory request/write
- mem_wstrb  out  `XLEN/8  shared memory byte strobes
- mem_addr/mem_wdata  out  `XLEN  shared memory address/write data
- mem_ready  in  1  memory accepts the request
- mem_rvalid  in  1  read response valid
- mem_rdata  in  `XLEN  read response data

Behaviour:
- Transfer: a request is accepted in a cycle where mem_req & mem_ready. Only reads produce mem_rvalid; writes complete on acceptance.
- Responses return in order, at least 1 cycle after acceptance.
- Reset values: owner FIFO empty, count=0, lock clear, round-robin pointer=DRAM. Because the FIFO is empty, iram_rvalid=dram_rvalid=0. mem_req=0 whenever no port requests.
- Grant (combinational):
  - If lock is set, the locked owner wins.
  - Else fixed priority: DRAM over IRAM.
  - No grant when the FIFO is full and the candidate request is a read. A write may still be granted with the FIFO full.
- Mux: mem_* = fields of the granted port. mem_req = granted port's req.
- Ready: <port>_ready = granted==port & mem_req & mem_ready. A non-granted port's ready is 0.
- Lock register:
  - Set to the granted owner when mem_req & !mem_ready.
  - Cleared on acceptance.
  - A stalled request therefore keeps its address/data on the bus until accepted. The lock may not change even if the higher-priority port requests.
  - The lock is also held while the FIFO is full for a locked read.
- Owner FIFO:
  - Push the granted owner on acceptance of a read (mem_write=0).
  - Pop on mem_rvalid.
  - Simultaneous push and pop is legal at any occupancy, including full: count is unchanged.
  - Pointers wrap modulo MAX_OUTSTANDING.
- Response routing:
  - The head owner selects the port: <head>_rvalid = mem_rvalid.
  - Both rdata outputs = mem_rdata, qualified only by rvalid.
- mem_rvalid with an empty FIFO: ignored; no port rvalid; the FIFO is unchanged. Simulation assertion fires.
- Reset asserted mid-operation: FIFO flushed, lock cleared. Responses still in flight are dropped; the system resets memory together with the arbiter.

Optional Feature:
- MEM_ARB_ROUND_ROBIN_EN defined:
  - When both ports request and no lock is set, the port != rr pointer wins.
  - The rr pointer is updated to the accepted owner on each acceptance.
  - Reset pointer is DRAM, so IRAM wins the first contest.
- Undefined: fixed priority DRAM > IRAM; no pointer register.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic {OWNER_IRAM=1'b0, OWNER_DRAM=1'b1} owner_e
  - localparam default MAX_OUTSTANDING
- Sub-module mem_arb_owner_fifo: synchronous FIFO of owner_e.
  - Ports: push, pop, din, dout, full, empty, count.
  - Async active-low reset.
  - Handles simultaneous push/pop at full.

Test Plan:
- Both ports issue reads simultaneously (iram addr 0x100, dram addr 0x200), mem_ready=1, fixed priority -> cycle 0: mem_addr=0x200, dram_ready=1. Cycle 1: mem_addr=0x100. Responses 0xAAAA/0xBBBB go to dram_rvalid then iram_rvalid.
- dram read stalled (mem_ready=0 for 3 cycles) while iram requests -> mem_addr stays dram addr all 4 cycles. iram_ready=0 until the cycle after dram acceptance.
- MAX_OUTSTANDING=2: three iram reads with no rvalid -> third read gets iram_ready=0, mem_req=0. An rvalid in the same cycle as the retry -> third read accepted, count stays 2.
- dram write (wstrb 4'b0011, wdata 0x1234) then iram read -> write takes no FIFO entry. The first mem_rvalid goes to iram_rvalid only.
- MEM_ARB_ROUND_ROBIN_EN: both ports request continuously for 4 accepts -> grants IRAM, DRAM, IRAM, DRAM.
- rst_b pulsed low with 2 reads outstanding, then a stray mem_rvalid -> no port rvalid, FIFO empty, assertion logged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// Data width comes from the XLEN macro; defaults to 32 when not set.
`ifndef XLEN
`define XLEN 32
`endif

package mem_arb_pkg;

    typedef enum logic {
        OWNER_IRAM = 1'b0,
        OWNER_DRAM = 1'b1
    } owner_e;

    localparam int DEFAULT_MAX_OUTSTANDING = 2;

endpackage

// File: rtl/mem_arb_owner_fifo.sv
// In-order FIFO of read owners; one entry per read still awaiting its response.
// A push is accepted when full only if a pop happens in the same cycle.
module mem_arb_owner_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_MAX_OUTSTANDING,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          push,
    input  logic          pop,
    input  owner_e        din,
    output owner_e        dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    owner_e        slots [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = slots[rptr];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) slots[i] <= OWNER_IRAM;
        end else begin
            if (do_push) begin
                slots[wptr] <= din;
                wptr        <= next_ptr(wptr);
            end
            if (do_pop) rptr <= next_ptr(rptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction and data ports, routing reads back in order.
// Optional MEM_ARB_ROUND_ROBIN_EN replaces DRAM-first priority with round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  iram_req,
    input  logic                  iram_write,
    input  logic [`XLEN/8-1:0]    iram_wstrb,
    input  logic [`XLEN-1:0]      iram_addr,
    input  logic [`XLEN-1:0]      iram_wdata,
    output logic                  iram_ready,
    output logic                  iram_rvalid,
    output logic [`XLEN-1:0]      iram_rdata,
    input  logic                  dram_req,
    input  logic                  dram_write,
    input  logic [`XLEN/8-1:0]    dram_wstrb,
    input  logic [`XLEN-1:0]      dram_addr,
    input  logic [`XLEN-1:0]      dram_wdata,
    output logic                  dram_ready,
    output logic                  dram_rvalid,
    output logic [`XLEN-1:0]      dram_rdata,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic [`XLEN/8-1:0]    mem_wstrb,
    output logic [`XLEN-1:0]      mem_addr,
    output logic [`XLEN-1:0]      mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [`XLEN-1:0]      mem_rdata
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    owner_e          cand;
    owner_e          lock_owner;
    logic            lock_valid;
    logic            sel_dram;
    logic            cand_req;
    logic            blocked;
    logic            accept;
    owner_e          head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_e rr_ptr;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)      rr_ptr <= OWNER_DRAM;
        else if (accept) rr_ptr <= cand;
    end
`endif

    always_comb begin
        cand = OWNER_IRAM;
        if (lock_valid) begin
            cand = lock_owner;
        end else if (dram_req && iram_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            cand = (rr_ptr == OWNER_DRAM) ? OWNER_IRAM : OWNER_DRAM;
`else
            cand = OWNER_DRAM;
`endif
        end else if (dram_req) begin
            cand = OWNER_DRAM;
        end
    end

    assign sel_dram  = (cand == OWNER_DRAM);
    assign cand_req  = sel_dram ? dram_req   : iram_req;
    assign mem_write = sel_dram ? dram_write : iram_write;
    assign mem_wstrb = sel_dram ? dram_wstrb : iram_wstrb;
    assign mem_addr  = sel_dram ? dram_addr  : iram_addr;
    assign mem_wdata = sel_dram ? dram_wdata : iram_wdata;

    // A read needs a free owner slot; a same-cycle response frees one.
    assign blocked    = ~mem_write & fifo_full & ~mem_rvalid;
    assign mem_req    = cand_req & ~blocked;
    assign accept     = mem_req & mem_ready;
    assign iram_ready = accept & ~sel_dram;
    assign dram_ready = accept & sel_dram;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            lock_valid <= 1'b0;
            lock_owner <= OWNER_IRAM;
        end else if (accept) begin
            lock_valid <= 1'b0;
        end else if (mem_req) begin
            lock_valid <= 1'b1;
            lock_owner <= cand;
        end
    end

    mem_arb_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_fifo (
        .clk   (clk),
        .rst_b (rst_b),
        .push  (accept & ~mem_write),
        .pop   (mem_rvalid),
        .din   (cand),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign iram_rvalid = mem_rvalid & ~fifo_empty & (head == OWNER_IRAM);
    assign dram_rvalid = mem_rvalid & ~fifo_empty & (head == OWNER_DRAM);
    assign iram_rdata  = mem_rdata;
    assign dram_rdata  = mem_rdata;

    stray_rvalid: assert property (@(posedge clk) disable iff (!rst_b)
        !(mem_rvalid && fifo_empty))
        else $warning("mem_arbiter: mem_rvalid with no read outstanding, ignored");

    count_bound: assert property (@(posedge clk) disable iff (!rst_b)
        fifo_count <= CW'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed per-cycle vector bench for mem_arbiter, default depth of 2.
// Expectations follow MEM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int XL = `XLEN;
    localparam int SW = XL / 8;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          iram_req = 0, iram_write = 0;
    logic [SW-1:0] iram_wstrb = '0;
    logic [XL-1:0] iram_addr = '0, iram_wdata = '0;
    logic          iram_ready, iram_rvalid;
    logic [XL-1:0] iram_rdata;
    logic          dram_req = 0, dram_write = 0;
    logic [SW-1:0] dram_wstrb = '0;
    logic [XL-1:0] dram_addr = '0, dram_wdata = '0;
    logic          dram_ready, dram_rvalid;
    logic [XL-1:0] dram_rdata;
    logic          mem_req, mem_write;
    logic [SW-1:0] mem_wstrb;
    logic [XL-1:0] mem_addr, mem_wdata;
    logic          mem_ready = 0, mem_rvalid = 0;
    logic [XL-1:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst_b(rst_b),
        .iram_req(iram_req), .iram_write(iram_write),
        .iram_wstrb(iram_wstrb), .iram_addr(iram_addr),
        .iram_wdata(iram_wdata), .iram_ready(iram_ready),
        .iram_rvalid(iram_rvalid), .iram_rdata(iram_rdata),
        .dram_req(dram_req), .dram_write(dram_write),
        .dram_wstrb(dram_wstrb), .dram_addr(dram_addr),
        .dram_wdata(dram_wdata), .dram_ready(dram_ready),
        .dram_rvalid(dram_rvalid), .dram_rdata(dram_rdata),
        .mem_req(mem_req), .mem_write(mem_write),
        .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic          rst;
        logic          ir, iw;
        logic [XL-1:0] ia;
        logic          dr, dw;
        logic [XL-1:0] da;
        logic [SW-1:0] dws;
        logic [XL-1:0] dwd;
        logic          mr, mv;
        logic [XL-1:0] md;
        logic          em, ew;
        logic [XL-1:0] ea;
        logic [SW-1:0] es;
        logic [XL-1:0] ed;
        logic          eir, edr, eiv, edv;
    } vec_t;

    vec_t vecs[$];

    task automatic add(
        input logic rst, ir, iw, input logic [XL-1:0] ia,
        input logic dr, dw, input logic [XL-1:0] da,
        input logic [SW-1:0] dws, input logic [XL-1:0] dwd,
        input logic mr, mv, input logic [XL-1:0] md,
        input logic em, ew, input logic [XL-1:0] ea,
        input logic [SW-1:0] es, input logic [XL-1:0] ed,
        input logic eir, edr, eiv, edv);
        vec_t v;
        v = '{rst, ir, iw, ia, dr, dw, da, dws, dwd, mr, mv, md,
              em, ew, ea, es, ed, eir, edr, eiv, edv};
        vecs.push_back(v);
    endtask

    // Idle cycle, optionally with a response from memory.
    task automatic idle(input logic rst, mv, input logic [XL-1:0] md,
                        input logic eiv, edv);
        add(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0, mv, md,
            0, 0, 0, 0, 0, 0, 0, eiv, edv);
    endtask

    // Single-port read cycle with memory ready.
    task automatic iread(input logic [XL-1:0] a);
        add(0, 1, 0, a, 0, 0, 0, 0, 0, 1, 0, 0,
            1, 0, a, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic dread(input logic [XL-1:0] a);
        add(0, 0, 0, 0, 1, 0, a, 0, 0, 1, 0, 0,
            1, 0, a, 0, 0, 0, 1, 0, 0);
    endtask

    initial begin
        logic [XL+SW+XL+6:0] got_v, exp_v;
        vec_t e;

        // Reset and idle
        idle(1, 0, 0, 0, 0);
        idle(0, 0, 0, 0, 0);
        // Simultaneous reads, then in-order responses
        add(0, 1, 0, 'h100, 1, 0, 'h200, 0, 0, 1, 0, 0,
            1, 0, RR ? 'h100 : 'h200, 0, 0, RR, !RR, 0, 0);
        if (RR) dread('h200);
        else    iread('h100);
        idle(0, 1, 'hAAAA, RR, !RR);
        idle(0, 1, 'hBBBB, !RR, RR);
        // DRAM read stalled 3 cycles; IRAM joins and must wait
        add(0, 0, 0, 0, 1, 0, 'h300, 0, 0, 0, 0, 0,
            1, 0, 'h300, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++)
            add(0, 1, 0, 'h104, 1, 0, 'h300, 0, 0, 0, 0, 0,
                1, 0, 'h300, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 'h104, 1, 0, 'h300, 0, 0, 1, 0, 0,
            1, 0, 'h300, 0, 0, 0, 1, 0, 0);
        iread('h104);
        idle(0, 1, 'h1111, 0, 1);
        idle(0, 1, 'h2222, 1, 0);
        // Owner FIFO full: third read blocked, then accepted with a response
        iread('h10);
        iread('h14);
        add(0, 1, 0, 'h18, 0, 0, 0, 0, 0, 1, 0, 0,
            0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 'h18, 0, 0, 0, 0, 0, 1, 1, 'hC1,
            1, 0, 'h18, 0, 0, 1, 0, 1, 0);
        idle(0, 1, 'hC2, 1, 0);
        idle(0, 1, 'hC3, 1, 0);
        // Write takes no owner slot
        add(0, 0, 0, 0, 1, 1, 'h400, 'h3, 'h1234, 1, 0, 0,
            1, 1, 'h400, 'h3, 'h1234, 0, 1, 0, 0);
        iread('h500);
        idle(0, 1, 'hDD, 1, 0);
        // Two DRAM reads in flight, reset, stray response
        dread('h600);
        dread('h604);
        idle(1, 0, 0, 0, 0);
        idle(0, 1, 'hEE, 0, 0);
        // Contention over four writes from reset pointer
        for (int i = 0; i < 4; i++) begin
            logic ipick;
            ipick = RR && (i % 2 == 0);
            add(0, 1, 1, 'h700, 1, 1, 'h800, 0, 0, 1, 0, 0,
                1, 1, ipick ? 'h700 : 'h800, 0, 0, ipick, !ipick, 0, 0);
        end
        // Flushed FIFO: next response belongs to the new IRAM read
        iread('h900);
        idle(0, 1, 'hFF, 1, 0);
        idle(0, 0, 0, 0, 0);

        for (int n = 0; n < vecs.size(); n++) begin
            e = vecs[n];
            @(negedge clk);
            rst_b      = !e.rst;
            iram_req   = e.ir;
            iram_write = e.iw;
            iram_addr  = e.ia;
            dram_req   = e.dr;
            dram_write = e.dw;
            dram_addr  = e.da;
            dram_wstrb = e.dws;
            dram_wdata = e.dwd;
            mem_ready  = e.mr;
            mem_rvalid = e.mv;
            mem_rdata  = e.md;
            #4;
            if (e.em) begin
                got_v = {mem_req, mem_write, mem_addr, mem_wstrb, mem_wdata,
                         iram_ready, dram_ready, iram_rvalid, dram_rvalid};
                exp_v = {e.em, e.ew, e.ea, e.es, e.ed,
                         e.eir, e.edr, e.eiv, e.edv};
            end else begin
                got_v = '0;
                exp_v = '0;
                got_v[4:0] = {mem_req, iram_ready, dram_ready,
                              iram_rvalid, dram_rvalid};
                exp_v[4:0] = {e.em, e.eir, e.edr, e.eiv, e.edv};
            end
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL row%0d bus: got %h want %h", n, got_v, exp_v);
            end
            if (e.mv) begin
                checks++;
                if (iram_rdata !== e.md || dram_rdata !== e.md) begin
                    errors++;
                    $display("FAIL row%0d rdata: got %h/%h want %h",
                             n, iram_rdata, dram_rdata, e.md);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
